// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM states,
// instruction field bit positions and the default sequential PC step.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned OP_MSB    = 27;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 25;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned RN_MSB    = 19;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned SRC2_MSB  = 11;
  localparam int unsigned SRC2_LSB  = 0;

  localparam int unsigned PC_STEP_DEFAULT = 4;

  // A redirect target is misaligned when either low address bit is set.
  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational split of a 32-bit ARM-style instruction word into the
// decoder fields Cond/Op/Funct/Rn/Rd/Src2.
module instr_field_split
  import ifu_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [3:0]  cond_o,
  output logic [1:0]  op_o,
  output logic [5:0]  funct_o,
  output logic [3:0]  rn_o,
  output logic [3:0]  rd_o,
  output logic [11:0] src2_o
);

  assign cond_o  = ir_i[COND_MSB:COND_LSB];
  assign op_o    = ir_i[OP_MSB:OP_LSB];
  assign funct_o = ir_i[FUNCT_MSB:FUNCT_LSB];
  assign rn_o    = ir_i[RN_MSB:RN_LSB];
  assign rd_o    = ir_i[RD_MSB:RD_LSB];
  assign src2_o  = ir_i[SRC2_MSB:SRC2_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/issue front end: owns the PC, fetches over a req/ack port, holds the IR
// and presents decoded fields. Optional counters enabled by IFU_PERF_CNT_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [3:0]        Cond,
  output logic [1:0]        Op,
  output logic [5:0]        Funct,
  output logic [3:0]        Rn,
  output logic [3:0]        Rd,
  output logic [11:0]       Src2,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus8,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       redirect_cnt,
`endif
  output logic              align_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              align_q, align_d;

  // Next-state, PC and IR update for the boot/fetch/issue sequence.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    align_d = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (stall) begin
          state_d = S_ISSUE;
        end else if (PCSrc) begin
          pc_d    = {branch_target[ADDR_W-1:2], 2'b00};
          align_d = misaligned(branch_target[1:0]);
          state_d = S_FETCH;
        end else begin
          pc_d    = pc_q + ADDR_W'(PC_STEP);
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State, PC, IR and alignment-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0000_0000;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      align_q <= align_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign align_err   = align_q;
  assign pc_out      = pc_q;
  assign pc_plus8    = pc_q + ADDR_W'(32'd8);

  instr_field_split u_split (
    .ir_i    (ir_q),
    .cond_o  (Cond),
    .op_o    (Op),
    .funct_o (Funct),
    .rn_o    (Rn),
    .rd_o    (Rd),
    .src2_o  (Src2)
  );

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] redirect_cnt_q;

  // Saturating counters of accepted fetches and taken redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q    <= 32'h0000_0000;
      redirect_cnt_q <= 16'h0000;
    end else begin
      if ((state_q == S_FETCH) && imem_ack && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q;
      end
      if ((state_q == S_ISSUE) && !stall && PCSrc && (redirect_cnt_q != 16'hFFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end else begin
        redirect_cnt_q <= redirect_cnt_q;
      end
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a memory/downstream driver
// predicts the issue stream, a separate monitor checks what the DUT presents.
module tb_instr_fetch_unit;

  localparam int NUM_ISSUES = 300;
  localparam int MAX_CYC    = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [11:0] Src2;
  logic [31:0] pc_out;
  logic [31:0] pc_plus8;
  logic        align_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [15:0] redirect_cnt;
`endif

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .Cond          (Cond),
    .Op            (Op),
    .Funct         (Funct),
    .Rn            (Rn),
    .Rd            (Rd),
    .Src2          (Src2),
    .pc_out        (pc_out),
    .pc_plus8      (pc_plus8),
`ifdef IFU_PERF_CNT_EN
    .fetch_cnt     (fetch_cnt),
    .redirect_cnt  (redirect_cnt),
`endif
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem[logic [31:0]];
  logic        exp_align;
  int          vectors    = 0;
  int          miscompares = 0;

  // Directed opening: per-fetch ack delay, per-issue stall/redirect choices.
  int          tbl_delay[5] = '{0, 3, 0, 0, 1};
  int          tbl_stall[5] = '{0, 5, 0, 0, 0};
  logic        tbl_take[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] tbl_tgt[5]   = '{32'h0, 32'h0000_0100, 32'h0000_0102, 32'hFFFF_FFFC, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom();
    return mem[a];
  endfunction

  // Driver: instruction memory responder plus downstream stall/redirect source.
  initial begin
    int          cyc, iss_idx, fetch_idx, wait_cnt, delay, stall_left;
    logic        pending, issue_open, did_reset, late_ack, take;
    logic [31:0] model_pc, tgt, nxt;
    cyc = 0; iss_idx = 0; fetch_idx = 0; wait_cnt = 0; delay = 0; stall_left = 0;
    pending = 1'b0; issue_open = 1'b0; did_reset = 1'b0; late_ack = 1'b0;
    rst = 1'b1; stall = 1'b0; PCSrc = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0; exp_align = 1'b0;
    mem[32'h0] = 32'hE28F_1004;
    model_pc = 32'h0;
    exp_q.push_back('{pc: 32'h0, word: mem_word(32'h0)});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (iss_idx < NUM_ISSUES && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      rst           = 1'b0;
      imem_ack      = 1'b0;
      imem_rdata    = $urandom();
      exp_align     = 1'b0;
      stall         = 1'($urandom_range(0, 1));
      PCSrc         = 1'($urandom_range(0, 1));
      branch_target = $urandom();
      if (late_ack) begin
        imem_ack = 1'b1;
        stall    = 1'b0;
        late_ack = 1'b0;
      end else if (imem_req && !did_reset && iss_idx >= 150) begin
        // Reset mid-fetch; the ack that follows must be ignored.
        rst = 1'b1; did_reset = 1'b1; late_ack = 1'b1;
        pending = 1'b0; issue_open = 1'b0;
        stall = 1'b0; PCSrc = 1'b0;
        exp_q.delete();
        model_pc = 32'h0;
        exp_q.push_back('{pc: 32'h0, word: mem_word(32'h0)});
      end else if (imem_req) begin
        if (!pending) begin
          pending  = 1'b1;
          wait_cnt = 0;
          delay    = (fetch_idx < 5) ? tbl_delay[fetch_idx] : int'($urandom_range(0, 3));
        end
        if (wait_cnt == delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          pending    = 1'b0;
          fetch_idx++;
        end else begin
          wait_cnt++;
        end
      end else begin
        imem_ack = ($urandom_range(0, 3) == 0);
      end
      if (instr_valid && !rst) begin
        if (!issue_open) begin
          issue_open = 1'b1;
          stall_left = (iss_idx < 5) ? tbl_stall[iss_idx]
                     : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        if (stall_left > 0) begin
          stall = 1'b1;
          stall_left--;
          if (iss_idx < 5) PCSrc = 1'b1;
        end else begin
          if (iss_idx < 5) begin
            take = tbl_take[iss_idx];
            tgt  = tbl_tgt[iss_idx];
          end else begin
            take = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
              0:       tgt = $urandom();
              1:       tgt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
              2:       tgt = 32'($urandom_range(0, 63));
              default: tgt = $urandom() & 32'hFFFF_FFFC;
            endcase
          end
          stall         = 1'b0;
          PCSrc         = take;
          branch_target = tgt;
          nxt           = take ? (tgt & 32'hFFFF_FFFC) : (model_pc + 32'd4);
          exp_align     = take && (tgt % 4 != 0);
          model_pc      = nxt;
          exp_q.push_back('{pc: nxt, word: mem_word(nxt)});
          issue_open    = 1'b0;
          iss_idx++;
        end
      end
    end
    if (iss_idx < NUM_ISSUES) chk("timeout_issues", 32'(iss_idx), 32'(NUM_ISSUES));
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: checks every cycle just after the rising edge against the scoreboard.
  initial begin
    logic req_b, valid_b, exp_v;
    int   n_issued;
    exp_t cur;
    req_b = 1'b0; valid_b = 1'b0; n_issued = 0;
    cur = '{pc: 32'h0, word: 32'h0};
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_align", 32'(align_err), 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_fields", {Cond, Op, Funct, Rn, Rd, Src2}, 32'h0);
        req_b   = 1'b0;
        valid_b = 1'b0;
      end else begin
        exp_v = (req_b & imem_ack) | (valid_b & stall);
        chk("valid_timing", 32'(instr_valid), 32'(exp_v));
        chk("align_err", 32'(align_err), 32'(exp_align));
        chk("req_valid_excl", 32'(imem_req & instr_valid), 32'h0);
        if (imem_req) begin
          if (exp_q.size() == 0) chk("fetch_unexpected", 32'h1, 32'h0);
          else chk("imem_addr", imem_addr, exp_q[0].pc);
        end
        if (instr_valid && !valid_b) begin
          if (exp_q.size() == 0) begin
            chk("issue_unexpected", 32'h1, 32'h0);
          end else begin
            cur = exp_q.pop_front();
          end
          n_issued++;
          if (n_issued == 1) begin
            chk("first_cond", 32'(Cond), 32'hE);
            chk("first_op", 32'(Op), 32'h0);
            chk("first_funct", 32'(Funct), 32'h28);
            chk("first_rn", 32'(Rn), 32'hF);
            chk("first_rd", 32'(Rd), 32'h1);
            chk("first_src2", 32'(Src2), 32'h004);
            chk("first_pc_plus8", pc_plus8, 32'h8);
          end
        end
        if (instr_valid) begin
          chk("pc_out", pc_out, cur.pc);
          chk("pc_plus8", pc_plus8, cur.pc + 32'd8);
          chk("fields", {Cond, Op, Funct, Rn, Rd, Src2}, cur.word);
        end
        req_b   = imem_req;
        valid_b = instr_valid;
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch/issue front end that drives the instruction-field inputs of the ARM-style ControlUnit decoder and consumes its PCSrc redirect. Owns the PC, fetches 32-bit words over a simple req/ack instruction-memory port, and holds the instruction register. It splits the held word into Cond/Op/Funct/Rd/Rn/Src2 and presents them with a valid qualifier. Sits between instruction memory and ControlUnit.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, byte increment for sequential fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held until ack
imem_addr  out  ADDR_W  fetch address (= PC), stable while imem_req
imem_ack  in  1  rdata valid this cycle; ignored when imem_req=0
imem_rdata  in  32  instruction word
stall  in  1  downstream not ready; freeze issued instruction
PCSrc  in  1  redirect from ControlUnit, sampled only when instr_valid & ~stall
branch_target  in  ADDR_W  redirect address
instr_valid  out  1  decoder fields valid
Cond  out  4  IR[31:28]
Op  out  2  IR[27:26]
Funct  out  6  IR[25:20]
Rn  out  4  IR[19:16]
Rd  out  4  IR[15:12]
Src2  out  12  IR[11:0]
pc_out  out  ADDR_W  address of issued instruction
pc_plus8  out  ADDR_W  pc_out + 8 (R15 read value)
align_err  out  1  one-cycle pulse on misaligned redirect

Behaviour:
- Clock clk, reset rst: synchronous, active-high; all state updates on rising clk.
- Reset: state=S_BOOT, PC=RESET_PC, IR=0, imem_req=0, instr_valid=0, align_err=0; decoded fields read 0.
- FSM states: S_BOOT, S_FETCH, S_ISSUE.
- S_BOOT: one cycle after rst released -> S_FETCH.
- S_FETCH: imem_req=1, imem_addr=PC. No ack -> stay. imem_ack=1 -> IR<=imem_rdata, -> S_ISSUE. instr_valid=0 throughout.
- S_ISSUE: instr_valid=1, fields from IR, imem_req=0.
  - stall=1: hold IR, PC, state; PCSrc ignored.
  - stall=0, PCSrc=0: PC<=PC+PC_STEP (wraps mod 2^ADDR_W), -> S_FETCH.
  - stall=0, PCSrc=1: PC<={branch_target[ADDR_W-1:2],2'b00}, -> S_FETCH; if branch_target[1:0]!=0, align_err=1 next cycle only.
- Latency: ack in cycle N -> instr_valid in cycle N+1; minimum issue period 2 cycles (fetch + issue) with zero-wait memory.
- pc_out=PC, pc_plus8=PC+8 (wraps), combinational from PC.
- imem_addr must not change while imem_req=1 and no ack.
- rst asserted mid-fetch or mid-stall: next cycle reset values; outstanding request abandoned, late ack after reset ignored (S_BOOT drops req).
- PC at 2^ADDR_W-4 sequential: wraps to 0, no error.

Optional Feature:
IFU_PERF_CNT_EN: adds outputs fetch_cnt[31:0] (increments each imem_ack accepted in S_FETCH) and redirect_cnt[15:0] (increments each taken PCSrc redirect); both saturate at all-ones and clear on rst. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Shared package ifu_pkg: fetch state enum (S_BOOT/S_FETCH/S_ISSUE), field bit-position localparams (COND_MSB=31 ... SRC2_LSB=0), PC_STEP default.
- One sub-module natural: instr_field_split (combinational IR -> Cond/Op/Funct/Rn/Rd/Src2), reusable by the ControlUnit bench.

Test Plan:
- Reset then zero-wait memory returning 32'hE28F_1004 at addr 0 -> imem_addr=0, instr_valid cycle after ack, Cond=4'hE, Op=2'b00, Funct=6'b101000, Rn=4'hF, Rd=4'h1, Src2=12'h004, pc_plus8=8; next imem_addr=4.
- ack delayed 3 cycles -> imem_req held, imem_addr stable at 4, instr_valid=0 until cycle after ack.
- stall=1 for 5 cycles in S_ISSUE with PCSrc=1 -> fields and pc_out frozen, no redirect; on stall=0 with PCSrc=1, branch_target=32'h100 -> next imem_addr=32'h100.
- PCSrc=1, branch_target=32'h0000_0102 -> imem_addr=32'h100, align_err pulses exactly one cycle.
- RESET_PC=32'hFFFF_FFFC, sequential issue -> next imem_addr=0, align_err=0.
- rst asserted while imem_req waiting, ack arrives the cycle after -> instr_valid stays 0, IR=0, fetch restarts at RESET_PC.
